// File: rtl/imem_arbiter.sv
// Two-requester arbiter (fetch / loader) for a 1024-word synchronous-read instruction memory.
// Optional build macro: IMEM_ARB_MISALIGN_CHECK_EN (flags misaligned fetches instead of reading).
module imem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int LOADER_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_LD = 2'd2
    } owner_t;

    localparam logic [3:0] BURST = 4'(LOADER_BURST);

    owner_t     r_owner;
    owner_t     w_owner_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       w_if_gnt;
    logic       w_ld_gnt;
    logic       w_mis;
    logic       w_unused_bits;

`ifdef IMEM_ARB_MISALIGN_CHECK_EN
    assign w_mis = (if_addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    assign w_unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                             ld_addr[31:ADDR_W+2], ld_addr[1:0]};

    // Owner, contention counter and misalign flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= IDLE;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Grant decision and next owner/counter; fetch wins contention only once the loader used its burst
    always_comb begin
        w_if_gnt    = 1'b0;
        w_ld_gnt    = 1'b0;
        w_owner_nxt = IDLE;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        if (!rst_n) begin
            w_cnt_nxt = 4'd0;
        end else if (if_req && (!ld_req || (r_cnt >= BURST))) begin
            w_if_gnt    = 1'b1;
            w_owner_nxt = RD_IF;
            w_cnt_nxt   = 4'd0;
            w_err_nxt   = w_mis;
        end else if (ld_req) begin
            w_ld_gnt    = 1'b1;
            w_owner_nxt = ld_we ? IDLE : RD_LD;
            if (if_req && (r_cnt < BURST)) begin
                w_cnt_nxt = r_cnt + 4'd1;
            end else begin
                w_cnt_nxt = r_cnt;
            end
        end else begin
            w_owner_nxt = IDLE;
        end
    end

    assign if_gnt    = w_if_gnt;
    assign ld_gnt    = w_ld_gnt;
    assign mem_en    = w_ld_gnt | (w_if_gnt & ~w_mis);
    assign mem_we    = w_ld_gnt & ld_we;
    assign mem_addr  = w_if_gnt ? if_addr[ADDR_W+1:2] : ld_addr[ADDR_W+1:2];
    assign mem_wdata = (w_ld_gnt && ld_we) ? ld_wdata : {DATA_W{1'b0}};

    assign if_rvalid = (r_owner == RD_IF);
    assign if_err    = if_rvalid & r_err;
    assign if_rdata  = (if_rvalid && !r_err) ? mem_rdata : {DATA_W{1'b0}};
    assign ld_rvalid = (r_owner == RD_LD);
    assign ld_rdata  = ld_rvalid ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: memory model, reference memory and per-requester scoreboards.
module tb_imem_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BURST  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'd0;
    logic              if_gnt, if_rvalid, if_err;
    logic [DATA_W-1:0] if_rdata;
    logic              ld_req = 1'b0;
    logic              ld_we = 1'b0;
    logic [31:0]       ld_addr = 32'd0;
    logic [DATA_W-1:0] ld_wdata = 32'd0;
    logic              ld_gnt, ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = 32'd0;

    logic [DATA_W-1:0] mem    [0:1023];
    logic [DATA_W-1:0] refmem [0:1023];
    logic [32:0]       if_q[$];
    logic [32:0]       ld_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int m_cnt = 0;
    logic m_if_v = 1'b0;
    logic m_ld_v = 1'b0;

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOADER_BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: sampled at the falling edge, mid-cycle
    always @(negedge clk) begin
        logic ig, lg, mis;
        logic [32:0] e;
        if (!rst_n) begin
            check_eq("rst_if_gnt", {32'd0, if_gnt}, 33'd0);
            check_eq("rst_ld_gnt", {32'd0, ld_gnt}, 33'd0);
            check_eq("rst_mem_en", {31'd0, mem_en, mem_we}, 33'd0);
            check_eq("rst_rvalid", {30'd0, if_rvalid, ld_rvalid, if_err}, 33'd0);
            check_eq("rst_rdata", {1'b0, if_rdata | ld_rdata}, 33'd0);
            m_if_v = 1'b0;
            m_ld_v = 1'b0;
            m_cnt  = 0;
            if_q.delete();
            ld_q.delete();
        end else begin
            check_eq("if_rvalid", {32'd0, if_rvalid}, {32'd0, m_if_v});
            if (m_if_v) begin
                check_eq("if_q_nonempty", {32'd0, (if_q.size() != 0)}, 33'd1);
                if (if_q.size() != 0) begin
                    e = if_q.pop_front();
                    check_eq("if_rdata_err", {if_err, if_rdata}, e);
                end
            end else begin
                check_eq("if_idle_zero", {if_err, if_rdata}, 33'd0);
            end
            check_eq("ld_rvalid", {32'd0, ld_rvalid}, {32'd0, m_ld_v});
            if (m_ld_v) begin
                check_eq("ld_q_nonempty", {32'd0, (ld_q.size() != 0)}, 33'd1);
                if (ld_q.size() != 0) begin
                    e = ld_q.pop_front();
                    check_eq("ld_rdata", {1'b0, ld_rdata}, e);
                end
            end else begin
                check_eq("ld_idle_zero", {1'b0, ld_rdata}, 33'd0);
            end

`ifdef IMEM_ARB_MISALIGN_CHECK_EN
            mis = (if_addr[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            ig = if_req && (!ld_req || (m_cnt == BURST));
            lg = ld_req && !ig;
            check_eq("if_gnt", {32'd0, if_gnt}, {32'd0, ig});
            check_eq("ld_gnt", {32'd0, ld_gnt}, {32'd0, lg});
            check_eq("mem_en", {32'd0, mem_en}, {32'd0, (lg || (ig && !mis))});
            check_eq("mem_we", {32'd0, mem_we}, {32'd0, (lg && ld_we)});
            if (ig && !mis) check_eq("mem_addr_if", {23'd0, mem_addr}, {23'd0, if_addr[11:2]});
            if (lg) check_eq("mem_addr_ld", {23'd0, mem_addr}, {23'd0, ld_addr[11:2]});
            if (lg && ld_we) check_eq("mem_wdata", {1'b0, mem_wdata}, {1'b0, ld_wdata});

            m_if_v = ig;
            m_ld_v = lg && !ld_we;
            if (ig) begin
                if_q.push_back(mis ? {1'b1, 32'd0} : {1'b0, refmem[if_addr[11:2]]});
                m_cnt = 0;
            end
            if (lg) begin
                if (ld_we) refmem[ld_addr[11:2]] = ld_wdata;
                else       ld_q.push_back({1'b0, refmem[ld_addr[11:2]]});
                if (if_req && m_cnt < BURST) m_cnt++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 32'h0101_0101 * i;
            refmem[i] = 32'h0101_0101 * i;
        end
        mem[5]    = 32'h8C22_0004;
        refmem[5] = 32'h8C22_0004;

        // reset with both requests pending, then release: loader takes the first cycle
        if_req = 1'b1; if_addr = 32'h14; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h20;
        tick(); tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("release_ld_first", {31'd0, ld_gnt, if_gnt}, 33'd2);
        #1;
        @(posedge clk); #1;
        if_req = 1'b0; ld_req = 1'b0;
        tick(); tick();

        // fetch only
        if_req = 1'b1; if_addr = 32'h14; tick();
        if_req = 1'b0; tick();

        // loader write then fetch of the same word
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h40; ld_wdata = 32'hDEAD_BEEF; tick();
        ld_req = 1'b0; if_req = 1'b1; if_addr = 32'h40; tick();
        if_req = 1'b0; tick();

        // wrapped, misaligned loader write lands on word 16
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h1043; ld_wdata = 32'h1234_5678; tick();
        ld_req = 1'b0; if_req = 1'b1; if_addr = 32'h40; tick();
        if_req = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40; tick();
        ld_req = 1'b0; tick();

        // sustained contention: L,L,L,L,F repeating
        if_req = 1'b1; if_addr = 32'h14; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_eq("contend_pattern", {31'd0, if_gnt, ld_gnt},
                     (i % 5 == 4) ? 33'd2 : 33'd1);
            @(posedge clk); #1;
        end
        if_req = 1'b0; ld_req = 1'b0; tick(); tick();

        // misaligned fetch
        if_req = 1'b1; if_addr = 32'h13; tick();
        if_req = 1'b0; tick();

        // reset while a fetch read is outstanding
        if_req = 1'b1; if_addr = 32'h14; tick();
        if_req = 1'b0; rst_n = 1'b0; tick(); tick();
        rst_n = 1'b1; tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester access controller for the 1024-word (4 KB) instruction memory. It shares the single memory port between the instruction-fetch stage (read-only) and the program loader/debug port (read/write), converts byte addresses to word indices, and returns read data one cycle after grant. It sits between the fetch stage and loader on one side and a synchronous-read instruction memory on the other.

## Interface
Parameters:
- ADDR_W, 10, word-index width (1024 words)
- DATA_W, 32, instruction width
- LOADER_BURST, 4, maximum consecutive contended loader grants before fetch is forced a slot (1..15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- if_err  out  1  misaligned-fetch flag, qualified by if_rvalid (see Configuration)
- ld_req  in  1  loader request; held with ld_we/ld_addr/ld_wdata until ld_gnt
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  32  loader byte address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader request accepted this cycle
- ld_rvalid  out  1  loader read data valid (reads only)
- ld_rdata  out  DATA_W  loader read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word index
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- Grant decision is combinational in the request cycle; memory is driven in the same cycle; at most one grant per cycle.
- Only one requester: it is granted immediately.
- Both requesting: loader wins unless the contention counter equals LOADER_BURST, in which case fetch wins.
- Contention counter: increments on a loader grant while if_req=1; clears on every fetch grant; saturates at LOADER_BURST.
- mem_addr = granted address bits [ADDR_W+1:2]; upper bits are ignored (wrap modulo 4 KB); loader bits [1:0] are always ignored.
- Owner register, states IDLE / RD_IF / RD_LD, records the read granted in cycle N:
  - fetch grant -> RD_IF
  - loader read grant -> RD_LD
  - loader write grant or no grant -> IDLE
- In cycle N+1: RD_IF asserts if_rvalid with if_rdata = mem_rdata; RD_LD asserts ld_rvalid with ld_rdata = mem_rdata.
- rdata outputs are 0 whenever the matching rvalid is low.
- Writes: completion is ld_gnt; there is no ld_rvalid.
- A new grant in cycle N+1 is legal while cycle N's data returns: full throughput, one access per cycle.

## Timing
- Read latency: grant cycle N, data cycle N+1, fixed.
- Reset (rst_n=0, asynchronous):
  - owner = IDLE, counter = 0
  - if_gnt, ld_gnt, mem_en, mem_we, both rvalids and if_err are forced 0
  - rdata outputs are 0
- Reset asserted with a read outstanding: the data is dropped and no rvalid is issued after release.
- First grant is possible in the first cycle with rst_n=1.
- Request dropped before grant: no access is performed and no state changes.

## Configuration
- IMEM_ARB_MISALIGN_CHECK_EN defined: a fetch with if_addr[1:0]≠0 is granted but mem_en stays 0. Next cycle if_rvalid=1, if_err=1, if_rdata=0. The contention counter treats it as a normal fetch grant.
- Undefined: if_addr[1:0] is ignored and if_err is tied 0.

## Test plan
- Reset: hold rst_n=0 with both reqs high -> all gnt/rvalid/mem_en = 0. Release -> loader is granted that cycle.
- Fetch only: preload word 5 = 0x8C220004, if_addr=0x14 -> if_gnt same cycle, mem_addr=5, if_rvalid next cycle with if_rdata=0x8C220004.
- Loader write then fetch read: ld_we=1, ld_addr=0x40, ld_wdata=0xDEADBEEF, then fetch 0x40 -> if_rdata=0xDEADBEEF. Wrap: ld_addr=0x1040 writes word 16.
- Contention, LOADER_BURST=4, both reqs continuously high -> grant pattern L,L,L,L,F repeating, one access per cycle, correct rvalid routing.
- Misaligned fetch 0x13 with macro defined -> mem_en=0, next cycle if_rvalid=1, if_err=1, if_rdata=0. Without macro -> word 4 returned, if_err=0.
- Reset mid-read: rst_n low in the cycle after a fetch grant -> if_rvalid=0 throughout, and no spurious rvalid after release.
